// File: rtl/stream_turbo_encode.sv
// Streaming rate-1/3 turbo encoder: ping-pong input banks feeding two 8-state RSC
// encoders (natural and interleaved order) with optional 3-symbol trellis termination.
module stream_turbo_encode #(
  parameter int unsigned N         = 64,
  parameter int unsigned TAIL_BITS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bit,
  output logic [$clog2(N)-1:0] il_addr,
  input  logic [$clog2(N)-1:0] il_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sys,
  output logic                 out_p1,
  output logic                 out_p2
);
  localparam int unsigned AW = $clog2(N);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  bank_q [2];
  logic [N-1:0]  bank_d [2];
  logic [1:0]    full_q, full_d;
  logic          fill_bank_q, fill_bank_d;
  logic          drain_bank_q, drain_bank_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    s1_q, s1_d, s2_q, s2_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic u1, u2, fb1, fb2, p1, p2, fire, drop_bank;

  // Encoder inputs: bank data in DATA, feedback-cancelling u = s2^s3 in TAIL (gives fb = 0).
  always_comb begin
    if (state_q == TAIL) begin
      u1 = s1_q[1] ^ s1_q[2];
      u2 = s2_q[1] ^ s2_q[2];
    end else begin
      u1 = bank_q[drain_bank_q][cnt_q];
      u2 = bank_q[drain_bank_q][il_data];
    end
    fb1  = u1 ^ s1_q[1] ^ s1_q[2];
    fb2  = u2 ^ s2_q[1] ^ s2_q[2];
    p1   = fb1 ^ s1_q[0] ^ s1_q[2];
    p2   = fb2 ^ s2_q[0] ^ s2_q[2];
    fire = out_valid_q && out_ready;
  end

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    full_d       = full_q;
    fill_bank_d  = fill_bank_q;
    fill_ptr_d   = fill_ptr_q;
    drain_bank_d = drain_bank_q;
    cnt_d        = cnt_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    drop_bank    = 1'b0;

    if (in_valid && in_ready_q) begin
      bank_d[fill_bank_q][fill_ptr_q] = in_bit;
      if (fill_ptr_q == AW'(N - 1)) begin
        full_d[fill_bank_q] = 1'b1;
        fill_ptr_d          = '0;
        fill_bank_d         = ~fill_bank_q;
      end else begin
        fill_ptr_d = fill_ptr_q + AW'(1);
      end
    end

    // State vector is {s3,s2,s1}; shifting in fb gives (fb,s1,s2).
    case (state_q)
      IDLE: begin
        if (full_q[drain_bank_q]) begin
          state_d = DATA;
          cnt_d   = '0;
          s1_d    = '0;
          s2_d    = '0;
        end
      end
      DATA: begin
        if (fire) begin
          s1_d = {s1_q[1:0], fb1};
          s2_d = {s2_q[1:0], fb2};
          if (cnt_q == AW'(N - 1)) begin
            cnt_d = '0;
            if (TAIL_BITS == 3) state_d = TAIL;
            else                drop_bank = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      TAIL: begin
        if (fire) begin
          s1_d = {s1_q[1:0], fb1};
          s2_d = {s2_q[1:0], fb2};
          if (cnt_q == AW'(2)) drop_bank = 1'b1;
          else                 cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A bank filling on this same edge counts, so streamed frames run back-to-back.
    if (drop_bank) begin
      full_d[drain_bank_q] = 1'b0;
      drain_bank_d         = ~drain_bank_q;
      cnt_d                = '0;
      s1_d                 = '0;
      s2_d                 = '0;
      state_d              = full_d[~drain_bank_q] ? DATA : IDLE;
    end

    in_ready_d  = !full_d[fill_bank_d];
    out_valid_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bank_q[0]    <= '0;
      bank_q[1]    <= '0;
      full_q       <= '0;
      fill_bank_q  <= 1'b0;
      fill_ptr_q   <= '0;
      drain_bank_q <= 1'b0;
      cnt_q        <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      full_q       <= full_d;
      fill_bank_q  <= fill_bank_d;
      fill_ptr_q   <= fill_ptr_d;
      drain_bank_q <= drain_bank_d;
      cnt_q        <= cnt_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign il_addr   = cnt_q;
  assign out_sys   = out_valid_q & u1;
  assign out_p1    = out_valid_q & p1;
  assign out_p2    = out_valid_q & p2;

endmodule

// File: tb/tb_stream_turbo_encode.sv
// Bench for stream_turbo_encode: instance 0 without tail, instance 1 with 3 tail symbols,
// both N = 8, checked against a bit-level RSC model and hand-derived vectors.
module tb_stream_turbo_encode;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in_valid_w = '0;
  logic [1:0] in_bit_w = '0;
  logic [1:0] out_ready_w = '0;
  wire  [1:0] in_ready_w, out_valid_w, out_sys_w, out_p1_w, out_p2_w;
  wire  [2:0] il_addr_w [2];
  logic [2:0] il_data_w [2];

  int perm [8];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int act = 0;
  bit collect_en = 1'b0;
  logic [2:0] got [$];
  logic [2:0] expq [$];
  logic [7:0] blks [$];
  int unstable, gaps, exp_total, accepted, acc_at_rel;
  int last_acc_cyc, first_valid_cyc;
  bit timed_out, ir_at_rel, held;
  logic [2:0] sym, held_sym;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    il_data_w[0] = 3'(perm[il_addr_w[0]]);
    il_data_w[1] = 3'(perm[il_addr_w[1]]);
  end

  stream_turbo_encode #(.N(8), .TAIL_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
    .in_bit(in_bit_w[0]), .il_addr(il_addr_w[0]), .il_data(il_data_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_w[0]), .out_sys(out_sys_w[0]),
    .out_p1(out_p1_w[0]), .out_p2(out_p2_w[0]));

  stream_turbo_encode #(.N(8), .TAIL_BITS(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
    .in_bit(in_bit_w[1]), .il_addr(il_addr_w[1]), .il_data(il_data_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_w[1]), .out_sys(out_sys_w[1]),
    .out_p1(out_p1_w[1]), .out_p2(out_p2_w[1]));

  // Symbol collector: records consumed symbols, stall stability and idle gaps mid-stream.
  always @(negedge clk) begin
    if (collect_en) begin
      if (out_valid_w[act]) begin
        sym = {out_sys_w[act], out_p1_w[act], out_p2_w[act]};
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (held && sym !== held_sym) unstable++;
        if (out_ready_w[act]) begin
          got.push_back(sym);
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_sym = sym;
        end
      end else begin
        held = 1'b0;
        if (out_ready_w[act] && got.size() > 0 && got.size() < exp_total) gaps++;
      end
    end
  end

  // Reference: two RSC(13,15) encoders applied bit by bit, plus zero-forcing tail.
  task automatic build_exp(input int tail);
    int a1, b1, c1, a2, b2, c2, u, v, f, g;
    expq.delete();
    foreach (blks[i]) begin
      a1 = 0; b1 = 0; c1 = 0; a2 = 0; b2 = 0; c2 = 0;
      for (int k = 0; k < 8; k++) begin
        u = int'(blks[i][k]);
        v = int'(blks[i][perm[k]]);
        f = u ^ b1 ^ c1;
        g = v ^ b2 ^ c2;
        expq.push_back({1'(u), 1'(f ^ a1 ^ c1), 1'(g ^ a2 ^ c2)});
        c1 = b1; b1 = a1; a1 = f;
        c2 = b2; b2 = a2; a2 = g;
      end
      if (tail == 3) begin
        for (int j = 0; j < 3; j++) begin
          expq.push_back({1'(b1 ^ c1), 1'(a1 ^ c1), 1'(a2 ^ c2)});
          c1 = b1; b1 = a1; a1 = 0;
          c2 = b2; b2 = a2; a2 = 0;
        end
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid_w = '0;
    out_ready_w = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_block(input int d, input logic [7:0] blk, input bit rnd);
    for (int k = 0; k < 8; k++) begin
      int wait_c = 0;
      bit acc = 1'b0;
      if (rnd && $urandom_range(0, 2) == 0) begin
        in_valid_w[d] = 1'b0;
        @(posedge clk); #1;
      end
      in_valid_w[d] = 1'b1;
      in_bit_w[d]   = blk[k];
      while (!acc) begin
        @(negedge clk);
        acc = in_ready_w[d];
        @(posedge clk); #1;
        if (acc) begin
          accepted++;
          if (k == 7) last_acc_cyc = cyc;
        end else if (++wait_c > 400) begin
          timed_out     = 1'b1;
          in_valid_w[d] = 1'b0;
          return;
        end
      end
    end
    in_valid_w[d] = 1'b0;
  endtask

  // mode 0: out_ready low for 40 cycles then high; 1: always high; 2: random both sides.
  task automatic run_blocks(input int d, input int mode);
    int cnt = 0;
    act = d; got.delete(); unstable = 0; gaps = 0; held = 1'b0;
    first_valid_cyc = -1; accepted = 0; timed_out = 1'b0;
    exp_total = blks.size() * ((d == 1) ? 11 : 8);
    collect_en = 1'b1;
    fork
      begin
        foreach (blks[i]) send_block(d, blks[i], mode == 2);
      end
      begin
        while (got.size() < exp_total && cnt < 2000) begin
          if (mode == 0)      out_ready_w[d] = (cnt >= 40);
          else if (mode == 1) out_ready_w[d] = 1'b1;
          else                out_ready_w[d] = 1'($urandom_range(0, 1));
          if (mode == 0 && cnt == 39) begin
            acc_at_rel = accepted;
            ir_at_rel  = in_ready_w[d];
          end
          @(posedge clk); #1;
          cnt++;
        end
        if (cnt >= 2000) timed_out = 1'b1;
        out_ready_w[d] = 1'b0;
      end
    join
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready_w[d] !== 1'b0) begin
        errors++; $display("FAIL rst_in_ready[%0d] got=%b exp=0", d, in_ready_w[d]);
      end
      checks++;
      if ({out_valid_w[d], out_sys_w[d], out_p1_w[d], out_p2_w[d]} !== 4'b0000) begin
        errors++; $display("FAIL rst_outputs[%0d] got=%b%b%b%b exp=0000", d,
                           out_valid_w[d], out_sys_w[d], out_p1_w[d], out_p2_w[d]);
      end
      checks++;
      if (il_addr_w[d] !== 3'd0) begin
        errors++; $display("FAIL rst_il_addr[%0d] got=%0d exp=0", d, il_addr_w[d]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready_w[d] !== 1'b1) begin
        errors++; $display("FAIL post_rst_in_ready[%0d] got=%b exp=1", d, in_ready_w[d]);
      end
    end
  endtask

  task automatic test_zeros();
    reset_dut();
    for (int k = 0; k < 8; k++) perm[k] = k;
    blks = '{8'h00};
    run_blocks(0, 1);
    checks++;
    if (timed_out || got.size() != 8) begin
      errors++; $display("FAIL zeros_count got=%0d exp=8 timeout=%0d", got.size(), timed_out);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 3'b000) begin
        errors++; $display("FAIL zeros_sym[%0d] got=%b exp=000", i, got[i]);
      end
    end
    checks++;
    if (first_valid_cyc - last_acc_cyc != 1) begin
      errors++; $display("FAIL latency got=%0d exp=1", first_valid_cyc - last_acc_cyc);
    end
  endtask

  task automatic test_impulse_tail();
    logic [2:0] ex [11];
    ex = '{3'b111, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 3'b011, 3'b000,
           3'b011, 3'b100, 3'b111};
    reset_dut();
    for (int k = 0; k < 8; k++) perm[k] = k;
    blks = '{8'h01, 8'h00};
    run_blocks(1, 1);
    checks++;
    if (timed_out || got.size() != 22) begin
      errors++; $display("FAIL impulse_count got=%0d exp=22 timeout=%0d", got.size(), timed_out);
    end
    for (int i = 0; i < 22 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== ((i < 11) ? ex[i] : 3'b000)) begin
        errors++; $display("FAIL impulse_sym[%0d] got=%b exp=%b", i, got[i],
                           (i < 11) ? ex[i] : 3'b000);
      end
    end
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL impulse_gaps got=%0d exp=0", gaps);
    end
  endtask

  task automatic test_reverse_il();
    logic [2:0] ex [8];
    ex = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b110};
    reset_dut();
    for (int k = 0; k < 8; k++) perm[k] = 7 - k;
    blks = '{8'h80};
    run_blocks(0, 1);
    checks++;
    if (timed_out || got.size() != 8) begin
      errors++; $display("FAIL rev_count got=%0d exp=8 timeout=%0d", got.size(), timed_out);
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== ex[i]) begin
        errors++; $display("FAIL rev_sym[%0d] got=%b exp=%b", i, got[i], ex[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    for (int k = 0; k < 8; k++) perm[k] = k;
    blks = '{8'($urandom), 8'($urandom), 8'($urandom)};
    build_exp(0);
    run_blocks(0, 0);
    checks++;
    if (acc_at_rel != 16 || ir_at_rel !== 1'b0) begin
      errors++; $display("FAIL bp_stall accepted=%0d in_ready=%b exp 16/0", acc_at_rel, ir_at_rel);
    end
    checks++;
    if (timed_out || got.size() != expq.size()) begin
      errors++; $display("FAIL bp_count got=%0d exp=%0d timeout=%0d", got.size(), expq.size(), timed_out);
    end
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== expq[i]) begin
        errors++; $display("FAIL bp_sym[%0d] got=%b exp=%b", i, got[i], expq[i]);
      end
    end
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL bp_gaps got=%0d exp=0", gaps);
    end
  endtask

  task automatic test_random_stall();
    for (int d = 0; d < 2; d++) begin
      reset_dut();
      for (int k = 0; k < 8; k++) perm[k] = k;
      for (int k = 7; k > 0; k--) begin
        int j = int'($urandom_range(0, k));
        int t = perm[k];
        perm[k] = perm[j];
        perm[j] = t;
      end
      blks = '{8'($urandom), 8'($urandom), 8'($urandom)};
      build_exp(d == 1 ? 3 : 0);
      run_blocks(d, 2);
      checks++;
      if (timed_out || got.size() != expq.size()) begin
        errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d timeout=%0d", d, got.size(),
                           expq.size(), timed_out);
      end
      for (int i = 0; i < expq.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== expq[i]) begin
          errors++; $display("FAIL rnd_sym[%0d][%0d] got=%b exp=%b", d, i, got[i], expq[i]);
        end
      end
      checks++;
      if (unstable != 0) begin
        errors++; $display("FAIL rnd_stable[%0d] changes=%0d exp=0", d, unstable);
      end
    end
  endtask

  task automatic test_mid_reset();
    int cnt = 0;
    reset_dut();
    for (int k = 0; k < 8; k++) perm[k] = k;
    act = 1; got.delete(); exp_total = 11; held = 1'b0; accepted = 0; timed_out = 1'b0;
    collect_en = 1'b1;
    send_block(1, 8'($urandom), 1'b0);
    send_block(1, 8'($urandom), 1'b0);
    out_ready_w[1] = 1'b1;
    while (got.size() < 4 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid_w[1] !== 1'b0 || in_ready_w[1] !== 1'b0) begin
      errors++; $display("FAIL midrst_async out_valid=%b in_ready=%b exp 0/0",
                         out_valid_w[1], in_ready_w[1]);
    end
    out_ready_w[1] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    blks = '{8'($urandom)};
    build_exp(3);
    run_blocks(1, 1);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (timed_out || got.size() != 11) begin
      errors++; $display("FAIL midrst_count got=%0d exp=11 timeout=%0d", got.size(), timed_out);
    end
    for (int i = 0; i < 11 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== expq[i]) begin
        errors++; $display("FAIL midrst_sym[%0d] got=%b exp=%b", i, got[i], expq[i]);
      end
    end
    collect_en = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) perm[k] = k;
    test_reset();
    test_zeros();
    test_impulse_tail();
    test_reverse_il();
    test_backpressure();
    test_random_stall();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
